opb_register_master: RTL and testbench
======================================

// Module: opb_register_master
// PURPOSE
//   OPB bus master that runs single-beat register read/write transactions on behalf of user logic.
//   It is the initiator for the opb_register_simulink2ppc / ppc2simulink slave registers.
//   It sits on the OPB_Clk domain, between a fabric-side command/response port and the OPB arbiter/bus.
//   Bus errors, retries and timeouts are reported back as a status code.
// PARAMETERS
//   C_OPB_AWIDTH  32        OPB address width
//   C_OPB_DWIDTH  32        OPB data width
//   C_TIMEOUT     16        cycles with M_select high and no ack/toutSup before local timeout (>=2)
//   C_MAX_RETRY   4         OPB_retry responses tolerated before giving up (0 = no retry)
//   C_FAMILY      "virtex6" target family
// PORTS
//   OPB_Clk       in   1          bus clock; all logic in this domain
//   OPB_Rst_n     in   1          asynchronous active-low reset
//   cmd_valid     in   1          command request
//   cmd_ready     out  1          high only in IDLE; accept on cmd_valid&cmd_ready
//   cmd_rnw       in   1          1=read, 0=write
//   cmd_addr      in   [0:31]     byte address
//   cmd_be        in   [0:3]      byte enables
//   cmd_wdata     in   [0:31]     write data
//   rsp_valid     out  1          one-cycle pulse, transaction finished
//   rsp_rdata     out  [0:31]     read data (valid with rsp_valid; 0 for writes)
//   rsp_status    out  2          00 ok, 01 errAck, 10 timeout, 11 retries exhausted
//   M_request     out  1          bus request to arbiter
//   M_select      out  1          master owns bus / transfer active
//   M_ABus        out  [0:31]    address; 0 when M_select=0
//   M_BE          out  [0:3]      byte enables; 0 when M_select=0
//   M_DBus        out  [0:31]    write data; 0 unless M_select & ~M_RNW (OR-bus)
//   M_RNW         out  1          0 when M_select=0
//   M_seqAddr     out  1          tied 0 (single-beat only)
//   OPB_MGrant    in   1          grant from arbiter
//   OPB_xferAck   in   1          slave transfer ack
//   OPB_errAck    in   1          slave error ack
//   OPB_retry     in   1          slave retry
//   OPB_toutSup   in   1          slave timeout suppress
//   OPB_timeout   in   1          arbiter timeout
//   OPB_DBus      in   [0:31]     read data bus
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0 except cmd_ready=1; retry/timeout counters 0.
//   Reset mid-transaction: bus outputs drop immediately; no rsp_valid is produced.
//   Accept: cmd fields are latched on cmd_valid&cmd_ready and are stable for the whole transaction.
//   IDLE -> REQ on accept. REQ: M_request=1.
//   REQ -> XFER on an edge with OPB_MGrant=1. In XFER: M_request=0, M_select=1, buses driven.
//   XFER, on an edge, priority errAck > xferAck > retry > timeout:
//     errAck   -> DONE, status 01, rdata captured from OPB_DBus if read.
//     xferAck  -> DONE, status 00, rdata=OPB_DBus if read, else 0.
//     retry    -> M_select drops next cycle; retry_cnt++.
//                 retry_cnt < C_MAX_RETRY: -> REQ. Otherwise -> DONE, status 11.
//     timeout  -> DONE, status 10. Fires on OPB_timeout=1, or when tout_cnt reaches C_TIMEOUT-1 with
//                 OPB_toutSup=0 on that edge.
//   tout_cnt: cleared on entering XFER; holds while OPB_toutSup=1; counts otherwise.
//   DONE lasts one cycle: M_select=0, rsp_valid=1, then -> IDLE (cmd_ready=1 next cycle).
//   Latency with immediate grant and ack: accept@0, M_request@1, M_select@2, xferAck sampled@2,
//     rsp_valid@3, cmd_ready@4.
//   Acks sampled while not in XFER are ignored. retry_cnt is cleared on accept.
// TESTING
//   Write A=0x01004100 BE=F D=0xDEADBEEF, grant@1, xferAck 2nd XFER cycle -> M_DBus=0xDEADBEEF while
//     selected; rsp_status=00; buses 0 after.
//   Read, slave drives 0x12345678 with xferAck -> rsp_rdata=0x12345678, status 00, M_DBus=0 throughout.
//   Grant delayed 5 cycles -> M_request high 5 cycles, M_select never high before grant.
//   OPB_retry x2 then xferAck, C_MAX_RETRY=4 -> three REQ phases, status 00.
//   OPB_retry x5 -> status 11 after the 5th retry.
//   No ack, C_TIMEOUT=16 -> status 10 after 16 select cycles. With toutSup held 40 cycles then xferAck
//     -> status 00.
//   errAck+xferAck on the same cycle -> status 01.
//   Reset asserted during XFER -> outputs 0 asynchronously; no rsp_valid.

Source files
------------

// File: rtl/opb_register_master_if.sv
// Command/response port and OPB master-side bus signals of opb_register_master.
// "master" is the view of the bus master itself, "slave" the view of the fabric/bus around it.
interface opb_register_master_if #(
    parameter int C_OPB_AWIDTH = 32,
    parameter int C_OPB_DWIDTH = 32
);
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic                        cmd_rnw;
    logic [0:C_OPB_AWIDTH-1]     cmd_addr;
    logic [0:C_OPB_DWIDTH/8-1]   cmd_be;
    logic [0:C_OPB_DWIDTH-1]     cmd_wdata;

    logic                        rsp_valid;
    logic [0:C_OPB_DWIDTH-1]     rsp_rdata;
    logic [1:0]                  rsp_status;

    logic                        M_request;
    logic                        M_select;
    logic [0:C_OPB_AWIDTH-1]     M_ABus;
    logic [0:C_OPB_DWIDTH/8-1]   M_BE;
    logic [0:C_OPB_DWIDTH-1]     M_DBus;
    logic                        M_RNW;
    logic                        M_seqAddr;

    logic                        OPB_MGrant;
    logic                        OPB_xferAck;
    logic                        OPB_errAck;
    logic                        OPB_retry;
    logic                        OPB_toutSup;
    logic                        OPB_timeout;
    logic [0:C_OPB_DWIDTH-1]     OPB_DBus;

    modport master (
        input  cmd_valid, cmd_rnw, cmd_addr, cmd_be, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_status,
        output M_request, M_select, M_ABus, M_BE, M_DBus, M_RNW, M_seqAddr,
        input  OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup, OPB_timeout, OPB_DBus
    );

    modport slave (
        output cmd_valid, cmd_rnw, cmd_addr, cmd_be, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_status,
        input  M_request, M_select, M_ABus, M_BE, M_DBus, M_RNW, M_seqAddr,
        output OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup, OPB_timeout, OPB_DBus
    );
endinterface

// File: rtl/opb_register_master.sv
// Single-beat OPB register master: takes one command, arbitrates for the bus, runs the
// transfer with retry/timeout handling and returns read data plus a status code.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// REQ    | M_request high, waiting for OPB_MGrant
// XFER   | bus owned, address/data driven, waiting for ack/retry/timeout
// DONE   | one-cycle rsp_valid pulse with status and read data
module opb_register_master #(
    parameter int C_OPB_AWIDTH = 32,
    parameter int C_OPB_DWIDTH = 32,
    parameter int C_TIMEOUT    = 16,
    parameter int C_MAX_RETRY  = 4,
    parameter     C_FAMILY     = "virtex6"
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst_n,
    opb_register_master_if.master       bus
);
    localparam int BEW = C_OPB_DWIDTH / 8;
    localparam int TW  = $clog2(C_TIMEOUT + 1);
    localparam int RW  = $clog2(C_MAX_RETRY + 2);
    localparam logic [TW-1:0] TOUT_LAST = TW'(C_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(C_MAX_RETRY);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERRACK  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_RETRY   = 2'b11;

    if (C_TIMEOUT < 2 || C_FAMILY == "") begin : g_bad_cfg
        $error("opb_register_master: C_TIMEOUT must be >= 2 and C_FAMILY non-empty");
    end

    logic [1:0]              state;
    logic                    rnw_q;
    logic [0:C_OPB_AWIDTH-1] addr_q;
    logic [0:BEW-1]          be_q;
    logic [0:C_OPB_DWIDTH-1] wdata_q;
    logic [0:C_OPB_DWIDTH-1] rdata_q;
    logic [1:0]              status_q;
    logic [TW-1:0]           tout_cnt;
    logic [RW-1:0]           retry_cnt;
    logic                    sel;
    logic                    done;
    logic                    tout_hit;

    assign sel      = (state == S_XFER);
    assign done     = (state == S_DONE);
    assign tout_hit = bus.OPB_timeout || ((tout_cnt == TOUT_LAST) && !bus.OPB_toutSup);

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state     <= S_IDLE;
            rnw_q     <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            status_q  <= ST_OK;
            tout_cnt  <= '0;
            retry_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        rnw_q     <= bus.cmd_rnw;
                        addr_q    <= bus.cmd_addr;
                        be_q      <= bus.cmd_be;
                        wdata_q   <= bus.cmd_wdata;
                        rdata_q   <= '0;
                        status_q  <= ST_OK;
                        retry_cnt <= '0;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.OPB_MGrant) begin
                        tout_cnt <= '0;
                        state    <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (bus.OPB_errAck) begin
                        rdata_q  <= rnw_q ? bus.OPB_DBus : '0;
                        status_q <= ST_ERRACK;
                        state    <= S_DONE;
                    end else if (bus.OPB_xferAck) begin
                        rdata_q  <= rnw_q ? bus.OPB_DBus : '0;
                        status_q <= ST_OK;
                        state    <= S_DONE;
                    end else if (bus.OPB_retry) begin
                        // count compared before increment: C_MAX_RETRY retries re-arbitrate, the next gives up
                        retry_cnt <= retry_cnt + 1'b1;
                        if (retry_cnt < RETRY_MAX) begin
                            state <= S_REQ;
                        end else begin
                            status_q <= ST_RETRY;
                            state    <= S_DONE;
                        end
                    end else if (tout_hit) begin
                        status_q <= ST_TIMEOUT;
                        state    <= S_DONE;
                    end else if (!bus.OPB_toutSup) begin
                        tout_cnt <= tout_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // bus outputs decode straight from state so a reset clears them without waiting for a clock
    assign bus.cmd_ready  = (state == S_IDLE);
    assign bus.rsp_valid  = done;
    assign bus.rsp_rdata  = done ? rdata_q : '0;
    assign bus.rsp_status = done ? status_q : ST_OK;
    assign bus.M_request  = (state == S_REQ);
    assign bus.M_select   = sel;
    assign bus.M_ABus     = sel ? addr_q : '0;
    assign bus.M_BE       = sel ? be_q : '0;
    assign bus.M_DBus     = (sel && !rnw_q) ? wdata_q : '0;
    assign bus.M_RNW      = sel & rnw_q;
    assign bus.M_seqAddr  = 1'b0;

endmodule

// File: tb/tb_opb_register_master.sv
// Directed bench for opb_register_master: write/read, delayed grant, retries, timeouts,
// error ack priority and reset during a transfer.
module tb_opb_register_master;
    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   req_phases;

    opb_register_master_if bus ();

    opb_register_master dut (
        .OPB_Clk   (clk),
        .OPB_Rst_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // presents a command in IDLE, lets it be accepted, then scrambles the command inputs
    task automatic start_cmd(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wd);
        bus.cmd_valid = 1'b1;
        bus.cmd_rnw   = rnw;
        bus.cmd_addr  = addr;
        bus.cmd_be    = be;
        bus.cmd_wdata = wd;
        chk("accept_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_rnw   = ~rnw;
        bus.cmd_addr  = 32'hFFFF_FFFF;
        bus.cmd_be    = 4'h0;
        bus.cmd_wdata = 32'h5555_5555;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_rnw     = 1'b0;
        bus.cmd_addr    = '0;
        bus.cmd_be      = '0;
        bus.cmd_wdata   = '0;
        bus.OPB_MGrant  = 1'b0;
        bus.OPB_xferAck = 1'b0;
        bus.OPB_errAck  = 1'b0;
        bus.OPB_retry   = 1'b0;
        bus.OPB_toutSup = 1'b0;
        bus.OPB_timeout = 1'b0;
        bus.OPB_DBus    = '0;

        repeat (2) tick();
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_request",   32'(bus.M_request), 32'd0);
        chk("rst_select",    32'(bus.M_select),  32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_abus",      32'(bus.M_ABus),    32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_seqaddr",  32'(bus.M_seqAddr), 32'd0);

        // write, grant in first REQ cycle, xferAck in the second XFER cycle
        start_cmd(1'b0, 32'h0100_4100, 4'hF, 32'hDEAD_BEEF);
        chk("wr_request",    32'(bus.M_request), 32'd1);
        chk("wr_nosel",      32'(bus.M_select),  32'd0);
        chk("wr_busy",       32'(bus.cmd_ready), 32'd0);
        bus.OPB_MGrant = 1'b1;
        tick();
        bus.OPB_MGrant = 1'b0;
        chk("wr_select",     32'(bus.M_select),  32'd1);
        chk("wr_req_drop",   32'(bus.M_request), 32'd0);
        chk("wr_abus",       32'(bus.M_ABus),    32'h0100_4100);
        chk("wr_be",         32'(bus.M_BE),      32'hF);
        chk("wr_dbus",       32'(bus.M_DBus),    32'hDEAD_BEEF);
        chk("wr_rnw",        32'(bus.M_RNW),     32'd0);
        tick();
        chk("wr_dbus_2",     32'(bus.M_DBus),    32'hDEAD_BEEF);
        bus.OPB_xferAck = 1'b1;
        tick();
        bus.OPB_xferAck = 1'b0;
        chk("wr_rsp_valid",  32'(bus.rsp_valid),  32'd1);
        chk("wr_status",     32'(bus.rsp_status), 32'd0);
        chk("wr_rdata",      32'(bus.rsp_rdata),  32'd0);
        chk("wr_sel_after",  32'(bus.M_select),   32'd0);
        chk("wr_abus_after", 32'(bus.M_ABus),     32'd0);
        chk("wr_dbus_after", 32'(bus.M_DBus),     32'd0);
        tick();
        chk("wr_ready_back", 32'(bus.cmd_ready),  32'd1);
        chk("wr_rsp_drop",   32'(bus.rsp_valid),  32'd0);

        // read with immediate grant and ack
        start_cmd(1'b1, 32'h0100_4104, 4'hF, 32'hAAAA_AAAA);
        chk("rd_request",    32'(bus.M_request), 32'd1);
        bus.OPB_MGrant = 1'b1;
        tick();
        bus.OPB_MGrant  = 1'b0;
        chk("rd_select",     32'(bus.M_select),  32'd1);
        chk("rd_rnw",        32'(bus.M_RNW),     32'd1);
        chk("rd_dbus_zero",  32'(bus.M_DBus),    32'd0);
        bus.OPB_xferAck = 1'b1;
        bus.OPB_DBus    = 32'h1234_5678;
        tick();
        bus.OPB_xferAck = 1'b0;
        bus.OPB_DBus    = '0;
        chk("rd_rsp_valid",  32'(bus.rsp_valid),  32'd1);
        chk("rd_rdata",      32'(bus.rsp_rdata),  32'h1234_5678);
        chk("rd_status",     32'(bus.rsp_status), 32'd0);
        chk("rd_dbus_done",  32'(bus.M_DBus),     32'd0);
        tick();
        chk("rd_ready_back", 32'(bus.cmd_ready),  32'd1);
        chk("rd_rdata_drop", 32'(bus.rsp_rdata),  32'd0);

        // grant delayed 5 cycles; stray acks during REQ must be ignored
        start_cmd(1'b0, 32'h0000_0010, 4'h3, 32'h0000_00A5);
        for (int i = 0; i < 5; i++) begin
            chk("dly_request", 32'(bus.M_request), 32'd1);
            chk("dly_nosel",   32'(bus.M_select),  32'd0);
            bus.OPB_xferAck = (i == 1);
            bus.OPB_errAck  = (i == 1);
            bus.OPB_MGrant  = (i == 4);
            tick();
        end
        bus.OPB_MGrant = 1'b0;
        chk("dly_select",    32'(bus.M_select),  32'd1);
        chk("dly_req_drop",  32'(bus.M_request), 32'd0);
        chk("dly_be",        32'(bus.M_BE),      32'h3);
        bus.OPB_xferAck = 1'b1;
        tick();
        bus.OPB_xferAck = 1'b0;
        chk("dly_rsp_valid", 32'(bus.rsp_valid),  32'd1);
        chk("dly_status",    32'(bus.rsp_status), 32'd0);
        tick();

        // two retries then xferAck: three REQ phases, status ok
        start_cmd(1'b1, 32'h0000_0020, 4'hF, 32'h0);
        req_phases = 0;
        for (int r = 0; r < 2; r++) begin
            if (bus.M_request) req_phases++;
            bus.OPB_MGrant = 1'b1;
            tick();
            bus.OPB_MGrant = 1'b0;
            chk("rty2_select", 32'(bus.M_select), 32'd1);
            bus.OPB_retry = 1'b1;
            tick();
            bus.OPB_retry = 1'b0;
            chk("rty2_drop",   32'(bus.M_select), 32'd0);
        end
        if (bus.M_request) req_phases++;
        bus.OPB_MGrant = 1'b1;
        tick();
        bus.OPB_MGrant  = 1'b0;
        bus.OPB_xferAck = 1'b1;
        bus.OPB_DBus    = 32'h0BAD_F00D;
        tick();
        bus.OPB_xferAck = 1'b0;
        bus.OPB_DBus    = '0;
        chk("rty2_phases",    32'(req_phases),     32'd3);
        chk("rty2_rsp_valid", 32'(bus.rsp_valid),  32'd1);
        chk("rty2_status",    32'(bus.rsp_status), 32'd0);
        chk("rty2_rdata",     32'(bus.rsp_rdata),  32'h0BAD_F00D);
        tick();

        // five retries: the fifth exhausts the budget of four
        start_cmd(1'b0, 32'h0000_0030, 4'hF, 32'h1111_2222);
        for (int r = 0; r < 5; r++) begin
            chk("rty5_request", 32'(bus.M_request), 32'd1);
            bus.OPB_MGrant = 1'b1;
            tick();
            bus.OPB_MGrant = 1'b0;
            bus.OPB_retry  = 1'b1;
            tick();
            bus.OPB_retry  = 1'b0;
        end
        chk("rty5_rsp_valid", 32'(bus.rsp_valid),  32'd1);
        chk("rty5_status",    32'(bus.rsp_status), 32'd3);
        tick();

        // no ack: local timeout after 16 select cycles
        start_cmd(1'b1, 32'h0000_0040, 4'hF, 32'h0);
        bus.OPB_MGrant = 1'b1;
        tick();
        bus.OPB_MGrant = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("to_select",  32'(bus.M_select),  32'd1);
            chk("to_nodone",  32'(bus.rsp_valid), 32'd0);
            tick();
        end
        chk("to_rsp_valid",   32'(bus.rsp_valid),  32'd1);
        chk("to_status",      32'(bus.rsp_status), 32'd2);
        chk("to_sel_drop",    32'(bus.M_select),   32'd0);
        tick();

        // toutSup held for 40 cycles, then xferAck
        start_cmd(1'b0, 32'h0000_0050, 4'hF, 32'h3333_4444);
        bus.OPB_MGrant = 1'b1;
        tick();
        bus.OPB_MGrant  = 1'b0;
        bus.OPB_toutSup = 1'b1;
        for (int i = 0; i < 40; i++) begin
            chk("sup_select", 32'(bus.M_select), 32'd1);
            tick();
        end
        bus.OPB_toutSup = 1'b0;
        bus.OPB_xferAck = 1'b1;
        tick();
        bus.OPB_xferAck = 1'b0;
        chk("sup_rsp_valid",  32'(bus.rsp_valid),  32'd1);
        chk("sup_status",     32'(bus.rsp_status), 32'd0);
        tick();

        // errAck and xferAck together: error wins, read data still captured
        start_cmd(1'b1, 32'h0000_0060, 4'hF, 32'h0);
        bus.OPB_MGrant = 1'b1;
        tick();
        bus.OPB_MGrant  = 1'b0;
        bus.OPB_errAck  = 1'b1;
        bus.OPB_xferAck = 1'b1;
        bus.OPB_DBus    = 32'hCAFE_F00D;
        tick();
        bus.OPB_errAck  = 1'b0;
        bus.OPB_xferAck = 1'b0;
        bus.OPB_DBus    = '0;
        chk("err_rsp_valid",  32'(bus.rsp_valid),  32'd1);
        chk("err_status",     32'(bus.rsp_status), 32'd1);
        chk("err_rdata",      32'(bus.rsp_rdata),  32'hCAFE_F00D);
        tick();

        // arbiter timeout ends the transfer immediately
        start_cmd(1'b0, 32'h0000_0070, 4'hF, 32'h7777_8888);
        bus.OPB_MGrant = 1'b1;
        tick();
        bus.OPB_MGrant  = 1'b0;
        bus.OPB_timeout = 1'b1;
        tick();
        bus.OPB_timeout = 1'b0;
        chk("atout_rsp_valid", 32'(bus.rsp_valid),  32'd1);
        chk("atout_status",    32'(bus.rsp_status), 32'd2);
        tick();

        // reset in the middle of XFER
        start_cmd(1'b0, 32'h0000_0080, 4'hF, 32'h9999_AAAA);
        bus.OPB_MGrant = 1'b1;
        tick();
        bus.OPB_MGrant = 1'b0;
        chk("rstx_select",   32'(bus.M_select), 32'd1);
        chk("rstx_dbus",     32'(bus.M_DBus),   32'h9999_AAAA);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstx_sel_async",  32'(bus.M_select),  32'd0);
        chk("rstx_abus_async", 32'(bus.M_ABus),    32'd0);
        chk("rstx_dbus_async", 32'(bus.M_DBus),    32'd0);
        chk("rstx_be_async",   32'(bus.M_BE),      32'd0);
        chk("rstx_ready",      32'(bus.cmd_ready), 32'd1);
        bus.OPB_xferAck = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstx_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        bus.OPB_xferAck = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("rstx_after_rsp",   32'(bus.rsp_valid), 32'd0);
        chk("rstx_after_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rstx_after_sel",   32'(bus.M_select),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
